// File: rtl/ps2_host_tx_pkg.sv
// Shared state encoding, frame constants and cycle-count helpers
// for the PS/2 host-to-device transmitter.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE,
        S_ERROR
    } tx_state_e;

    localparam int unsigned FRAME_BITS = 11;
    // Falls 1..10 drive bits; the fall after the last driven bit is the ACK.
    localparam logic [3:0] LAST_DRIVEN = 4'(FRAME_BITS - 1);

    function automatic longint unsigned us_to_cyc(
        input longint unsigned hz,
        input longint unsigned us
    );
        return hz / 64'd1_000_000 * us;
    endfunction

    function automatic longint unsigned ms_to_cyc(
        input longint unsigned hz,
        input longint unsigned ms
    );
        return hz / 64'd1_000 * ms;
    endfunction

    function automatic longint unsigned max3(
        input longint unsigned a,
        input longint unsigned b,
        input longint unsigned c
    );
        longint unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// Pad synchronizer plus stability filter for one PS/2 line, with a
// one-cycle strobe on each accepted 1->0 transition.
module ps2_line_filter #(
    parameter int unsigned FILTER_CYC = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int unsigned CW = (FILTER_CYC > 1) ? $clog2(FILTER_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(FILTER_CYC - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        fall_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == LAST) begin
                level_d = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Idle bus level is high, so everything resets to 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host transmitter: request-to-send, bit shifting on device clock
// falls, ACK check and done/error reporting.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ  = 25_000_000,
    parameter int unsigned INHIBIT_US   = 100,
    parameter int unsigned START_TMO_MS = 15,
    parameter int unsigned PKT_TMO_MS   = 2,
    parameter int unsigned FILTER_CYC   = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam longint unsigned INH_CYC =
        us_to_cyc(64'(CLK_FREQ_HZ), 64'(INHIBIT_US));
    localparam longint unsigned START_CYC =
        ms_to_cyc(64'(CLK_FREQ_HZ), 64'(START_TMO_MS));
    localparam longint unsigned PKT_CYC =
        ms_to_cyc(64'(CLK_FREQ_HZ), 64'(PKT_TMO_MS));
    localparam longint unsigned MAX_CYC = max3(INH_CYC, START_CYC, PKT_CYC);
    localparam int unsigned TW = $clog2(MAX_CYC + 64'd1);

    localparam logic [TW-1:0] INH_LD   = TW'(INH_CYC - 64'd1);
    localparam logic [TW-1:0] START_LD = TW'(START_CYC - 64'd1);
    localparam logic [TW-1:0] PKT_LD   = TW'(PKT_CYC - 64'd1);

    tx_state_e     state_q, state_d;
    logic [9:0]    shreg_q, shreg_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;

    logic clk_lvl, clk_fall;
    logic data_lvl, data_fall_unused;
    logic tmo;

    ps2_line_filter #(.FILTER_CYC(FILTER_CYC)) u_clk_filt (
        .clk     (clk),
        .reset_n (reset_n),
        .line_i  (ps2_clk_in),
        .level_o (clk_lvl),
        .fall_o  (clk_fall)
    );

    ps2_line_filter #(.FILTER_CYC(FILTER_CYC)) u_data_filt (
        .clk     (clk),
        .reset_n (reset_n),
        .line_i  (ps2_data_in),
        .level_o (data_lvl),
        .fall_o  (data_fall_unused)
    );

    assign tmo = (tmr_q == '0);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        tmr_d     = tmo ? '0 : tmr_q - TW'(1);
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        unique case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    shreg_d  = {1'b1, ~^tx_data, tx_data};
                    cnt_d    = '0;
                    tmr_d    = INH_LD;
                    clk_oe_d = 1'b1;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (tmo) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    tmr_d     = START_LD;
                    state_d   = S_RTS;
                end
            end
            S_RTS: begin
                if (clk_fall) begin
                    data_oe_d = ~shreg_q[0];
                    shreg_d   = {1'b0, shreg_q[9:1]};
                    cnt_d     = 4'd1;
                    tmr_d     = PKT_LD;
                    state_d   = S_SHIFT;
                end else if (tmo) begin
                    state_d = S_ERROR;
                end
            end
            S_SHIFT: begin
                if (clk_fall) begin
                    data_oe_d = ~shreg_q[0];
                    shreg_d   = {1'b0, shreg_q[9:1]};
                    cnt_d     = cnt_q + 4'd1;
                    if (cnt_q == LAST_DRIVEN - 4'd1) begin
                        state_d = S_ACK;
                    end
                end else if (tmo) begin
                    state_d = S_ERROR;
                end
            end
            S_ACK: begin
                if (clk_fall) begin
                    state_d = data_lvl ? S_ERROR : S_WAIT_IDLE;
                end else if (tmo) begin
                    state_d = S_ERROR;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_lvl && data_lvl) begin
                    state_d = S_IDLE;
                end else if (tmo) begin
                    state_d = S_ERROR;
                end
            end
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_ERROR || state_d == S_IDLE) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            tmr_q     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
        end
    end

    assign tx_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign tx_error    = (state_q == S_ERROR);
    assign tx_done     = (state_q == S_WAIT_IDLE) && clk_lvl && data_lvl;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain device model, directed vector table,
// randomized bytes against a frame model, and timeout/reset corners.
module tb_ps2_host_tx;

    localparam int unsigned CLK_HZ    = 1_000_000;
    localparam int          INH_CYC   = CLK_HZ / 1_000_000 * 100;
    localparam int          START_CYC = CLK_HZ / 1_000 * 15;
    localparam int          PKT_CYC   = CLK_HZ / 1_000 * 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, busy;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_FREQ_HZ  (CLK_HZ),
        .INHIBIT_US   (100),
        .START_TMO_MS (15),
        .PKT_TMO_MS   (2),
        .FILTER_CYC   (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .busy        (busy),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Frame as the device sees it: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        int   ones;
        logic par;
        ones = $countones(d);
        par  = (ones % 2 == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            if (tx_done) done_cnt++;
            if (tx_error) err_cnt++;
            if (tx_done || tx_error) chk("done_err_excl", 32'(tx_done & tx_error), 0);
            if (prev_done) chk("ready_after_done", 32'(tx_ready), 1);
        end
        prev_done = reset_n && tx_done;
    end

    // mode: 0 ACK, 1 no ACK, 2 glitch + tx_valid while busy, 3 reset mid-packet
    task automatic run_pkt(input logic [7:0] d, input int mode, input int half,
                           input logic [10:0] exp_frame, input bit exp_done,
                           input bit exp_err, input string tag);
        int         n;
        int         d0, e0;
        logic [10:0] seen;
        d0 = done_cnt;
        e0 = err_cnt;
        seen = '0;
        n = 0;
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        n = 0;
        while (ps2_clk_oe && n < INH_CYC + 50) begin
            n++;
            @(negedge clk);
        end
        chk({tag, " inhibit_len"}, 32'(n), 32'(INH_CYC));
        chk({tag, " rts_data_oe"}, 32'(ps2_data_oe), 1);
        repeat (20) @(negedge clk);
        seen[0] = ps2_data_in;
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (half) @(negedge clk);
            if (mode == 3 && i == 4) begin
                chk({tag, " pre_rst_data_oe"}, 32'(ps2_data_oe), 1);
                #2 reset_n = 1'b0;
                #1 chk({tag, " async_rst_oe"}, 32'({ps2_clk_oe, ps2_data_oe}), 0);
                dev_clk_low = 1'b0;
                repeat (3) @(negedge clk);
                reset_n = 1'b1;
                repeat (20) @(negedge clk);
                chk({tag, " rst_ready_busy"}, 32'({tx_ready, busy}), 32'h2);
                chk({tag, " rst_no_pulse"}, 32'((done_cnt - d0) + (err_cnt - e0)), 0);
                return;
            end
            if (mode == 2 && i == 6) begin
                chk({tag, " busy_not_ready"}, 32'({tx_ready, busy}), 32'h1);
                tx_data  = 8'h5A;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
            dev_clk_low = 1'b0;
            seen[i] = ps2_data_in;
            if (mode == 2 && i == 4) begin
                repeat (half / 2) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (4) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (half - half / 2) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
        end
        if (mode != 1) dev_data_low = 1'b1;
        repeat (half / 2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (half) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (half / 2) @(negedge clk);
        dev_data_low = 1'b0;
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < PKT_CYC) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk({tag, " frame"}, 32'(seen), 32'(exp_frame));
        chk({tag, " done_pulses"}, 32'(done_cnt - d0), 32'(exp_done));
        chk({tag, " err_pulses"}, 32'(err_cnt - e0), 32'(exp_err));
        chk({tag, " idle_after"}, 32'({busy, ps2_clk_oe, ps2_data_oe}), 0);
    endtask

    typedef struct {
        logic [7:0]  data;
        int          mode;
        logic [10:0] frame;
        bit          done;
        bit          err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int n, d0, e0;
        logic [7:0] d;
        vecs[0] = '{8'hED, 0, 11'h7DA, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 0, 11'h600, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 0, 11'h7FE, 1'b1, 1'b0};
        vecs[3] = '{8'h01, 0, 11'h402, 1'b1, 1'b0};
        vecs[4] = '{8'h03, 0, 11'h606, 1'b1, 1'b0};
        vecs[5] = '{8'hED, 1, 11'h7DA, 1'b0, 1'b1};
        vecs[6] = '{8'hFF, 0, 11'h7FE, 1'b1, 1'b0};
        vecs[7] = '{8'hA5, 2, 11'h74A, 1'b1, 1'b0};

        repeat (4) @(negedge clk);
        chk("reset_outputs",
            32'({tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_error}),
            32'b100000);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            run_pkt(vecs[v].data, vecs[v].mode, 40, vecs[v].frame,
                    vecs[v].done, vecs[v].err, $sformatf("vec%0d", v));
        end

        for (int k = 0; k < 8; k++) begin
            d = 8'($urandom);
            run_pkt(d, 0, int'($urandom_range(25, 50)), model_frame(d),
                    1'b1, 1'b0, $sformatf("rnd%0d_%02h", k, d));
        end

        run_pkt(8'h00, 3, 40, 11'h000, 1'b0, 1'b0, "reset_mid");

        // Device never answers the request-to-send.
        d0 = done_cnt;
        e0 = err_cnt;
        tx_data  = 8'h42;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while (ps2_clk_oe && n < INH_CYC + 50) begin
            n++;
            @(negedge clk);
        end
        chk("silent inhibit_len", 32'(n), 32'(INH_CYC));
        n = 0;
        while (!tx_error && n < START_CYC + 100) begin
            @(negedge clk);
            n++;
        end
        chk("silent tmo_window",
            32'(n >= START_CYC - 1 && n <= START_CYC + 1), 1);
        chk("silent oe_released", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        repeat (3) @(negedge clk);
        chk("silent ready", 32'(tx_ready), 1);
        chk("silent pulses", 32'({done_cnt - d0, err_cnt - e0}), 32'({32'd0, 32'd1}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(10 * 200_000);
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors",
                 checks, errors);
        $fatal(1);
    end

endmodule
